// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants for the ID/EX pipeline slice: default
//               datapath width, ALU opcodes, skid-buffer state encoding and
//               the forwarding-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int C_XLEN = 32;

    // ALU opcodes carried through the stage untouched
    localparam logic [3:0] C_ALU_ADD = 4'b0000;
    localparam logic [3:0] C_ALU_SUB = 4'b0001;
    localparam logic [3:0] C_ALU_AND = 4'b0010;
    localparam logic [3:0] C_ALU_OR  = 4'b0011;
    localparam logic [3:0] C_ALU_XOR = 4'b0100;

    // Skid-buffer occupancy: nothing held, main only, main plus skid
    localparam logic [1:0] C_ST_EMPTY = 2'd0;
    localparam logic [1:0] C_ST_ONE   = 2'd1;
    localparam logic [1:0] C_ST_FULL  = 2'd2;

    // A later stage supplies a source operand when it writes a non-zero
    // register equal to the one being read; x0 is hardwired to zero.
    function automatic logic reg_match(input logic       we,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs);
        return we && (rd == rs) && (rd != 5'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Selects the freshest value for one source register. With
//               RISCV_FORWARDING_EN defined, the EX/MEM result wins over the
//               MEM/WB result, which wins over the register-file value.
//               Without it the register-file value passes straight through.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = C_XLEN
) (
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [4:0]      mem_rd,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_data,
    input  logic [4:0]      wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);

`ifdef RISCV_FORWARDING_EN
    // Priority select: youngest producer first, register file last
    always_comb begin
        fwd_data = rs_data;
        if (reg_match(mem_we, mem_rd, rs_addr)) begin
            fwd_data = mem_data;
        end else if (reg_match(wb_we, wb_rd, rs_addr)) begin
            fwd_data = wb_data;
        end
    end
`else
    assign fwd_data = rs_data;

    // Bypass sources stay on the interface but carry no meaning here
    logic w_unused;
    assign w_unused = ^{rs_addr, mem_rd, mem_we, mem_data, wb_rd, wb_we, wb_data};
`endif

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register built as a two-entry skid buffer
//               (main + skid). Operands are resolved (forwarded, immediate
//               selected) when an instruction is captured; outputs always
//               come from the main entry. flush empties the stage.
//               Optional feature macro: RISCV_FORWARDING_EN (operand bypass
//               from the MEM and WB stages).
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = C_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_use_imm,
    input  logic            in_reg_write,
    input  logic [3:0]      in_alu_ctrl,
    input  logic            flush,
    input  logic [4:0]      mem_rd,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_data,
    input  logic [4:0]      wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_alu_ctrl,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_in_ready;
    logic            r_ex_valid;

    logic [XLEN-1:0] r_main_a,  r_skid_a;
    logic [XLEN-1:0] r_main_b,  r_skid_b;
    logic [3:0]      r_main_alu, r_skid_alu;
    logic [4:0]      r_main_rd, r_skid_rd;
    logic            r_main_rw, r_skid_rw;

    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic            w_accept;
    logic            w_take;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr  (in_rs1_addr),
        .rs_data  (in_rs1_data),
        .mem_rd   (mem_rd),
        .mem_we   (mem_we),
        .mem_data (mem_data),
        .wb_rd    (wb_rd),
        .wb_we    (wb_we),
        .wb_data  (wb_data),
        .fwd_data (w_fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr  (in_rs2_addr),
        .rs_data  (in_rs2_data),
        .mem_rd   (mem_rd),
        .mem_we   (mem_we),
        .mem_data (mem_data),
        .wb_rd    (wb_rd),
        .wb_we    (wb_we),
        .wb_data  (wb_data),
        .fwd_data (w_fwd_rs2)
    );

    assign w_op_a   = w_fwd_rs1;
    assign w_op_b   = in_use_imm ? in_imm : w_fwd_rs2;

    // A flushed cycle never takes the incoming instruction
    assign w_accept = in_valid && r_in_ready && !flush;
    assign w_take   = r_ex_valid && ex_ready;

    // Occupancy transition; flush wins over every handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_EMPTY: begin
                if (w_accept) w_state_nxt = C_ST_ONE;
            end
            C_ST_ONE: begin
                if (w_accept && !w_take)      w_state_nxt = C_ST_FULL;
                else if (!w_accept && w_take) w_state_nxt = C_ST_EMPTY;
            end
            C_ST_FULL: begin
                if (w_take) w_state_nxt = C_ST_ONE;
            end
            default: w_state_nxt = C_ST_EMPTY;
        endcase
        if (flush) w_state_nxt = C_ST_EMPTY;
    end

    // State, registered handshakes and entry storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= C_ST_EMPTY;
            r_in_ready <= 1'b1;
            r_ex_valid <= 1'b0;
            r_main_a   <= '0;
            r_main_b   <= '0;
            r_main_alu <= '0;
            r_main_rd  <= '0;
            r_main_rw  <= 1'b0;
            r_skid_a   <= '0;
            r_skid_b   <= '0;
            r_skid_alu <= '0;
            r_skid_rd  <= '0;
            r_skid_rw  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ex_valid <= (w_state_nxt != C_ST_EMPTY);
            r_in_ready <= (w_state_nxt != C_ST_FULL);
            if (!flush) begin
                case (r_state)
                    C_ST_EMPTY: begin
                        if (w_accept) begin
                            r_main_a   <= w_op_a;
                            r_main_b   <= w_op_b;
                            r_main_alu <= in_alu_ctrl;
                            r_main_rd  <= in_rd_addr;
                            r_main_rw  <= in_reg_write;
                        end
                    end
                    C_ST_ONE: begin
                        // Main drains this cycle: new entry replaces it;
                        // otherwise it parks in the skid slot.
                        if (w_accept && w_take) begin
                            r_main_a   <= w_op_a;
                            r_main_b   <= w_op_b;
                            r_main_alu <= in_alu_ctrl;
                            r_main_rd  <= in_rd_addr;
                            r_main_rw  <= in_reg_write;
                        end else if (w_accept) begin
                            r_skid_a   <= w_op_a;
                            r_skid_b   <= w_op_b;
                            r_skid_alu <= in_alu_ctrl;
                            r_skid_rd  <= in_rd_addr;
                            r_skid_rw  <= in_reg_write;
                        end
                    end
                    C_ST_FULL: begin
                        if (w_take) begin
                            r_main_a   <= r_skid_a;
                            r_main_b   <= r_skid_b;
                            r_main_alu <= r_skid_alu;
                            r_main_rd  <= r_skid_rd;
                            r_main_rw  <= r_skid_rw;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign ex_valid     = r_ex_valid;
    assign ex_a         = r_main_a;
    assign ex_b         = r_main_b;
    assign ex_alu_ctrl  = r_main_alu;
    assign ex_rd        = r_main_rd;
    assign ex_reg_write = r_main_rw;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage: reset, single
//               issue, operand forwarding, stall/skid, flush, back-to-back
//               throughput and reset during a held transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      alu;
        logic [4:0]      rd;
    } xfer_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]      in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic            in_use_imm, in_reg_write;
    logic [3:0]      in_alu_ctrl;
    logic            flush;
    logic [4:0]      mem_rd, wb_rd;
    logic            mem_we, wb_we;
    logic [XLEN-1:0] mem_data, wb_data;
    logic            ex_valid, ex_ready;
    logic [XLEN-1:0] ex_a, ex_b;
    logic [3:0]      ex_alu_ctrl;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;

    int    vectors    = 0;
    int    miscompares = 0;
    xfer_t xq[$];

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_use_imm(in_use_imm), .in_reg_write(in_reg_write), .in_alu_ctrl(in_alu_ctrl),
        .flush(flush),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
    );

    always #5 clk = ~clk;

    // Log every execute-side transfer as it happens
    always @(posedge clk) begin
        if (rst_n && ex_valid && ex_ready)
            xq.push_back('{a: ex_a, b: ex_b, alu: ex_alu_ctrl, rd: ex_rd});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [3:0] alu, input logic [4:0] rd);
        in_rs1_data  = a;
        in_rs2_data  = b;
        in_imm       = '0;
        in_rs1_addr  = 5'd0;
        in_rs2_addr  = 5'd0;
        in_rd_addr   = rd;
        in_use_imm   = 1'b0;
        in_reg_write = 1'b1;
        in_alu_ctrl  = alu;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; ex_ready = 1'b0; flush = 1'b0;
        set_instr(32'h1234, 32'h5678, 4'h3, 5'd7);
        mem_rd = 5'd0; mem_we = 1'b0; mem_data = '0;
        wb_rd = 5'd0; wb_we = 1'b0; wb_data = '0;
        tick(); tick();
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++; if ({ex_a, ex_b} !== 64'h0) begin miscompares++; $display("FAIL reset_operands: got a=%h b=%h want 0", ex_a, ex_b); end
        vectors++; if ({ex_alu_ctrl, ex_rd, ex_reg_write} !== 10'h0) begin miscompares++; $display("FAIL reset_ctrl: got alu=%h rd=%0d rw=%b want 0", ex_alu_ctrl, ex_rd, ex_reg_write); end
        in_valid = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        ex_ready = 1'b0; in_valid = 1'b1;
        set_instr(32'd5, 32'd7, 4'b0000, 5'd9);
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL add_pre_valid: got %b want 0", ex_valid); end
        tick();
        in_valid = 1'b0;
        vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL add_latency: got %b want 1", ex_valid); end
        vectors++; if (ex_a !== 32'd5 || ex_b !== 32'd7) begin miscompares++; $display("FAIL add_operands: got a=%h b=%h want 5 7", ex_a, ex_b); end
        vectors++; if (ex_alu_ctrl !== 4'b0000 || ex_rd !== 5'd9 || ex_reg_write !== 1'b1) begin miscompares++; $display("FAIL add_ctrl: got alu=%h rd=%0d rw=%b want 0 9 1", ex_alu_ctrl, ex_rd, ex_reg_write); end
        ex_ready = 1'b1;
        tick();
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL add_drain: got %b want 0", ex_valid); end
    endtask

    task automatic test_forwarding();
        logic [XLEN-1:0] exp_mem, exp_wb, exp_b;
`ifdef RISCV_FORWARDING_EN
        exp_mem = 32'hAA; exp_wb = 32'hBB; exp_b = 32'hAA;
`else
        exp_mem = 32'h11; exp_wb = 32'h11; exp_b = 32'h22;
`endif
        ex_ready = 1'b1; in_valid = 1'b1;
        set_instr(32'h11, 32'h22, 4'h0, 5'd4);
        in_rs1_addr = 5'd3; in_rs2_addr = 5'd3;
        mem_rd = 5'd3; mem_we = 1'b1; mem_data = 32'hAA;
        wb_rd = 5'd3; wb_we = 1'b1; wb_data = 32'hBB;
        tick();
        vectors++; if (ex_a !== exp_mem) begin miscompares++; $display("FAIL fwd_mem_prio: got %h want %h", ex_a, exp_mem); end
        vectors++; if (ex_b !== exp_b) begin miscompares++; $display("FAIL fwd_rs2: got %h want %h", ex_b, exp_b); end
        mem_we = 1'b0;
        tick();
        vectors++; if (ex_a !== exp_wb) begin miscompares++; $display("FAIL fwd_wb: got %h want %h", ex_a, exp_wb); end
        in_rs1_addr = 5'd0; mem_rd = 5'd0; mem_we = 1'b1; wb_rd = 5'd0;
        tick();
        vectors++; if (ex_a !== 32'h11) begin miscompares++; $display("FAIL fwd_x0: got %h want 11", ex_a); end
        in_valid = 1'b0; mem_we = 1'b0; wb_we = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        logic [XLEN-1:0] exp_a [3];
        exp_a[0] = 32'h100; exp_a[1] = 32'h200; exp_a[2] = 32'h300;
        xq.delete();
        ex_ready = 1'b0; in_valid = 1'b1;
        set_instr(32'h100, 32'h1, 4'h1, 5'd1);
        tick();
        vectors++; if (ex_valid !== 1'b1 || in_ready !== 1'b1 || ex_a !== 32'h100) begin miscompares++; $display("FAIL stall_first: got v=%b rdy=%b a=%h want 1 1 100", ex_valid, in_ready, ex_a); end
        set_instr(32'h200, 32'h2, 4'h2, 5'd2);
        tick();
        vectors++; if (in_ready !== 1'b0 || ex_a !== 32'h100) begin miscompares++; $display("FAIL stall_full: got rdy=%b a=%h want 0 100", in_ready, ex_a); end
        set_instr(32'h300, 32'h3, 4'h4, 5'd3);
        tick();
        vectors++; if (in_ready !== 1'b0 || ex_a !== 32'h100) begin miscompares++; $display("FAIL stall_hold: got rdy=%b a=%h want 0 100", in_ready, ex_a); end
        ex_ready = 1'b1;
        tick();
        vectors++; if (in_ready !== 1'b1 || ex_a !== 32'h200) begin miscompares++; $display("FAIL stall_skid_move: got rdy=%b a=%h want 1 200", in_ready, ex_a); end
        tick();
        in_valid = 1'b0;
        vectors++; if (ex_a !== 32'h300 || ex_rd !== 5'd3) begin miscompares++; $display("FAIL stall_third: got a=%h rd=%0d want 300 3", ex_a, ex_rd); end
        tick();
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL stall_empty: got %b want 0", ex_valid); end
        vectors++; if (xq.size() !== 3) begin miscompares++; $display("FAIL stall_count: got %0d want 3", xq.size()); end
        for (int i = 0; i < 3 && i < xq.size(); i++) begin
            vectors++; if (xq[i].a !== exp_a[i]) begin miscompares++; $display("FAIL stall_order[%0d]: got %h want %h", i, xq[i].a, exp_a[i]); end
        end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0; in_valid = 1'b1;
        set_instr(32'h500, 32'h5, 4'h0, 5'd5);
        tick();
        set_instr(32'h600, 32'h6, 4'h0, 5'd6);
        tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_setup_full: got rdy=%b want 0", in_ready); end
        xq.delete();
        flush = 1'b1;
        set_instr(32'h700, 32'h7, 4'h0, 5'd7);
        tick();
        vectors++; if (ex_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_clear: got v=%b rdy=%b want 0 1", ex_valid, in_ready); end
        flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        tick(); tick(); tick();
        vectors++; if (xq.size() !== 0 || ex_valid !== 1'b0) begin miscompares++; $display("FAIL flush_nothing_presented: got xfers=%0d v=%b want 0 0", xq.size(), ex_valid); end
    endtask

    task automatic test_back_to_back();
        xq.delete();
        ex_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            set_instr(32'(i + 1), 32'hDEAD, 4'(i), 5'(i + 10));
            in_use_imm = 1'b1;
            in_imm = 32'hFFFFFFFC - 32'(i);
            tick();
            if (i == 0) begin
                vectors++; if (ex_valid !== 1'b1 || ex_b !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL b2b_imm: got v=%b b=%h want 1 fffffffc", ex_valid, ex_b); end
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++; if (xq.size() !== 10) begin miscompares++; $display("FAIL b2b_throughput: got %0d xfers in 11 cycles want 10", xq.size()); end
        for (int i = 0; i < 10 && i < xq.size(); i++) begin
            vectors++;
            if (xq[i].a !== 32'(i + 1) || xq[i].b !== 32'hFFFFFFFC - 32'(i) || xq[i].alu !== 4'(i) || xq[i].rd !== 5'(i + 10)) begin
                miscompares++;
                $display("FAIL b2b_entry[%0d]: got a=%h b=%h alu=%h rd=%0d want %h %h %h %0d", i, xq[i].a, xq[i].b, xq[i].alu, xq[i].rd, 32'(i + 1), 32'hFFFFFFFC - 32'(i), 4'(i), i + 10);
            end
        end
    endtask

    task automatic test_reset_midflight();
        ex_ready = 1'b0; in_valid = 1'b1;
        set_instr(32'h900, 32'h9, 4'h2, 5'd8);
        tick();
        vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_held: got %b want 1", ex_valid); end
        rst_n = 1'b0;
        tick();
        vectors++; if (ex_valid !== 1'b0 || in_ready !== 1'b1 || ex_a !== 32'h0 || ex_rd !== 5'd0) begin miscompares++; $display("FAIL rstmid_clear: got v=%b rdy=%b a=%h rd=%0d want 0 1 0 0", ex_valid, in_ready, ex_a, ex_rd); end
        rst_n = 1'b1; in_valid = 1'b0; ex_ready = 1'b1;
        tick();
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_discarded: got %b want 0", ex_valid); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_forwarding();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands and immediate.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid / in_ready  input / output  1 / 1  decode-side handshake; transfer when both high at clk edge.
REQ-005 in_rs1_data, in_rs2_data, in_imm  input  XLEN each  register-file operands and sign-extended immediate.
REQ-006 in_rs1_addr, in_rs2_addr, in_rd_addr  input  5 each  source/destination register indices.
REQ-007 in_use_imm, in_reg_write  input  1 each  select imm for operand B; instruction writes rd.
REQ-008 in_alu_ctrl  input  4  ALU opcode (0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR).
REQ-009 flush  input  1  discard all held instructions (branch taken).
REQ-010 mem_rd, mem_we, mem_data  input  5/1/XLEN  EX/MEM-stage forwarding source.
REQ-011 wb_rd, wb_we, wb_data  input  5/1/XLEN  MEM/WB-stage forwarding source.
REQ-012 ex_valid / ex_ready  output / input  1 / 1  execute-side handshake.
REQ-013 ex_a, ex_b  output  XLEN each  ALU operands a, b.
REQ-014 ex_alu_ctrl  output  4; ex_rd  output  5; ex_reg_write  output  1  forwarded to execute/writeback.

Function
REQ-015 Block SHALL be a 2-entry skid buffer (main + skid) with states EMPTY, ONE, FULL; outputs always driven from main entry.
REQ-016 in_ready SHALL be a registered signal, high iff state != FULL.
REQ-017 EMPTY: accept -> ONE; ex_valid SHALL rise the cycle after acceptance (latency 1).
REQ-018 ONE: accept with ex_ready -> ONE (main replaced); accept without ex_ready -> FULL (new entry in skid); ex_ready without accept -> EMPTY.
REQ-019 FULL: ex_ready -> ONE with skid moved to main; no accept possible.
REQ-020 Operand B SHALL be in_imm when in_use_imm=1, else forwarded rs2 value; operand A SHALL be forwarded rs1 value.
REQ-021 Forwarding SHALL be resolved at capture time: MEM source has priority over WB; source matches when we=1, rd equal and rd != 0; register 0 SHALL never be forwarded.
REQ-022 in_alu_ctrl SHALL pass unmodified, including undefined codes (ALU treats them as zero result).
REQ-023 flush SHALL clear both entries to EMPTY next cycle and drop any same-cycle input transfer; flush overrides accept and ex_ready.
REQ-024 Entries SHALL never be overwritten or lost while ex_ready=0; no bubble inserted when both sides are ready every cycle (full throughput).

Reset
REQ-025 rst_n=0 at a clk edge SHALL force state EMPTY, ex_valid=0, in_ready=1, ex_a=ex_b=0, ex_alu_ctrl=0, ex_rd=0, ex_reg_write=0; reset mid-transfer discards held entries.

Configuration
REQ-026 Macro RISCV_FORWARDING_EN: when defined, forwarding per REQ-021; when undefined, operands SHALL come directly from in_rs1_data/in_rs2_data, mem_*/wb_* ports remain present but ignored.

Structure
REQ-027 Shared package riscv_pkg SHALL hold XLEN, ALU opcode constants, and the skid-state encoding.
REQ-028 Forwarding selection SHALL be one sub-module fwd_mux, instantiated twice (rs1, rs2).

Verification
REQ-029 Reset then single ADD, rs1=5, rs2=7: ex_valid one cycle after accept, ex_a=5, ex_b=7, ex_alu_ctrl=0000.
REQ-030 in_rs1_addr=3, mem_rd=3 mem_we=1 mem_data=0xAA, wb_rd=3 wb_we=1 wb_data=0xBB -> ex_a=0xAA; with mem_we=0 -> 0xBB; with addr 0 -> raw rs1_data.
REQ-031 ex_ready held 0 for 3 cycles with in_valid=1: in_ready falls after second accept, both instructions emerge in order, none duplicated.
REQ-032 State FULL with flush=1 and in_valid=1 -> next cycle ex_valid=0, in_ready=1, no instruction ever presented.
REQ-033 Back-to-back 10 instructions with ex_ready=1: 10 ex transfers in 11 cycles; in_use_imm=1, imm=0xFFFFFFFC -> ex_b=0xFFFFFFFC.
REQ-034 Build without RISCV_FORWARDING_EN, repeat REQ-030 stimulus -> ex_a equals in_rs1_data.
